key_debounce_pulse: RTL

//   Conditions one raw board push-button (KEY) into clean, Clk_50-synchronous

---
 rtl/key_debounce_pulse.sv | 117 +++++++++++
 1 files changed

// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: 2-FF synchronizer, debounce FSM, press/release strobes
// and a wrapping press counter, all synchronous to Clk_50.
module key_debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    parameter int unsigned PRESS_CNT_W     = 8
) (
    input  logic                   Clk_50,
    input  logic                   Reset,
    input  logic                   Key_Raw,
    output logic                   Key_Level,
    output logic                   Key_Press,
    output logic                   Key_Release,
    output logic [PRESS_CNT_W-1:0] Press_Count
);

    localparam logic             IdleRaw = KEY_ACTIVE_LOW;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [PRESS_CNT_W-1:0] PressOne = PRESS_CNT_W'(1);

    typedef enum logic [1:0] {
        StReleased,
        StPressChk,
        StPressed,
        StReleaseChk
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sync1_q, sync2_q;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic [PRESS_CNT_W-1:0] count_q, count_d;
    logic                   key_s;

    // Normalise polarity so key_s = 1 always means "pressed".
    assign key_s = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_ff @(posedge Clk_50) begin
        if (Reset) begin
            sync1_q   <= IdleRaw;
            sync2_q   <= IdleRaw;
            state_q   <= StReleased;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= '0;
        end else begin
            sync1_q   <= Key_Raw;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
        end
    end

    // Bounce is tested before terminal count, so a glitch on the last cycle aborts the edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        count_d   = count_q;
        case (state_q)
            StReleased: begin
                if (key_s) begin
                    state_d = StPressChk;
                    cnt_d   = '0;
                end
            end
            StPressChk: begin
                if (!key_s) begin
                    state_d = StReleased;
                end else if (cnt_q == CntLast) begin
                    state_d = StPressed;
                    press_d = 1'b1;
                    level_d = 1'b1;
                    count_d = count_q + PressOne;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StPressed: begin
                if (!key_s) begin
                    state_d = StReleaseChk;
                    cnt_d   = '0;
                end
            end
            StReleaseChk: begin
                if (key_s) begin
                    state_d = StPressed;
                end else if (cnt_q == CntLast) begin
                    state_d   = StReleased;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: state_d = StReleased;
        endcase
    end

    assign Key_Level   = level_q;
    assign Key_Press   = press_q;
    assign Key_Release = release_q;
    assign Press_Count = count_q;

endmodule
